memory_row: RTL and testbench

MEMORY_ROW -- requirements
Module: memory_row

---
 rtl/memory_pkg.sv | 11 +
 rtl/memory_cell.sv | 33 +++
 rtl/memory_row.sv | 54 +++++
 tb/tb_memory_row.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the memory row: default row width, operation encodings and row data type.
package memory_pkg;

    localparam int ROW_WIDTH = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef logic [0:ROW_WIDTH-1] row_t;

endpackage

// File: rtl/memory_cell.sv
// Single storage bit: loads d on a selected write, holds otherwise, clears on synchronous reset.
module memory_cell
    import memory_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    input  logic op,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        if (sel && (op == OP_WRITE)) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/memory_row.sv
// WIDTH-bit memory row built from memory_cell instances with combinational read gating.
// Optional even-parity cell and parity_err output when MEMORY_ROW_PARITY_EN is defined.
module memory_row
    import memory_pkg::*;
#(
    parameter int WIDTH = ROW_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             S,
    input  logic             op,
    input  logic [0:WIDTH-1] data_input,
    output logic [0:WIDTH-1] data_output
`ifdef MEMORY_ROW_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    logic [0:WIDTH-1] stored;
    logic             rd_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        memory_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .sel   (S),
            .op    (op),
            .d     (data_input[i]),
            .q     (stored[i])
        );
    end

    assign rd_en = S && (op == OP_READ);

    // Output is forced to zero outside a read so writes and idle rows never drive data.
    assign data_output = rd_en ? stored : '0;

`ifdef MEMORY_ROW_PARITY_EN
    logic par_bit;

    memory_cell u_parity_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (S),
        .op    (op),
        .d     (^data_input),
        .q     (par_bit)
    );

    assign parity_err = rd_en && ((^stored) != par_bit);
`endif

endmodule

// File: tb/tb_memory_row.sv
// Randomized self-checking bench for memory_row against a behavioural row model.
module tb_memory_row;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         S;
    logic         op;
    logic [0:W-1] data_input;
    logic [0:W-1] data_output;
`ifdef MEMORY_ROW_PARITY_EN
    logic         parity_err;
    logic         par_now;
`endif

    int checks = 0;
    int errors = 0;

    logic [0:W-1] model_row;

    always #5 clk = ~clk;

    memory_row #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .S           (S),
        .op          (op),
        .data_input  (data_input),
        .data_output (data_output)
`ifdef MEMORY_ROW_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic o, input logic [0:W-1] d);
        @(negedge clk);
        rst_n      = r;
        S          = s;
        op         = o;
        data_input = d;
        #1;
    endtask

    // Model: row is a plain register updated from the values present at the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n)          model_row = '0;
        else if (S && op)    model_row = data_input;
        #1;
    endtask

    function automatic logic [0:W-1] model_out();
        return (S && !op) ? model_row : '0;
    endfunction

    initial begin
        model_row = 'x;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("reset_idle_out", data_output, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("reset_read_out", data_output, 8'h00);

        // Write, hold one edge, then read back.
        drive(1'b1, 1'b1, 1'b1, 8'b10101010);
        check("write_out_zero", data_output, 8'h00);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h55);
        check("idle_out_zero", data_output, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("read_aa", data_output, 8'b10101010);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'b11111111);
            check("read_hold_aa", data_output, 8'b10101010);
            tick();
        end

        drive(1'b1, 1'b1, 1'b1, 8'b11001100);
        check("write_cc_out_zero", data_output, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("read_cc", data_output, 8'b11001100);

        // Reset overrides a simultaneous write.
        drive(1'b1, 1'b1, 1'b1, 8'b11110000);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("read_f0", data_output, 8'b11110000);
        drive(1'b0, 1'b1, 1'b1, 8'b00001111);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("read_after_reset", data_output, 8'h00);

        // Select glitches between edges must not disturb storage.
        drive(1'b1, 1'b1, 1'b1, 8'h3C);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'hC3);
        #2 S = 1'b1; op = 1'b1;
        #1 S = 1'b0; op = 1'b0;
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("glitch_read", data_output, 8'h3C);

`ifdef MEMORY_ROW_PARITY_EN
        drive(1'b1, 1'b1, 1'b1, 8'b10000000);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("parity_ok", {63'd0, parity_err}, 64'd0);
        par_now = dut.u_parity_cell.q_q;
        force dut.u_parity_cell.q_q = ~par_now;
        #1;
        check("parity_flip_err", {63'd0, parity_err}, 64'd1);
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        check("parity_err_write_low", {63'd0, parity_err}, 64'd0);
        release dut.u_parity_cell.q_q;
        tick();
`endif

        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 15) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  W'($urandom));
            check("rand_out", data_output, model_out());
`ifdef MEMORY_ROW_PARITY_EN
            check("rand_parity", {63'd0, parity_err}, 64'd0);
`endif
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
